// File: rtl/encap_packet.sv
// Splits one captured DFX word into 19 link frames of 64 bits (55-bit payload + 9-bit header)
// and streams them out under valid/ready handshaking.
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  input  logic                         valid_dfx_in,
  output logic                         ready_dfx_in,
  output logic [AURORA_DATA_WIDTH-1:0] data_out_dfx,
  output logic                         valid_out_dfx,
  input  logic                         ready_out_dfx,
  output logic                         busy,
  output logic                         done_encap_pkt
);

  localparam int HDR_W      = 9;
  localparam int PAY_W      = AURORA_DATA_WIDTH - HDR_W;
  localparam int NUM_FRAMES = (DATA_DFX_WIDTH + PAY_W - 1) / PAY_W;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_FRAMES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                         state_r;
  logic [CNT_W-1:0]               cnt_r;
  logic [DATA_DFX_WIDTH-1:0]      word_r;
  logic [AURORA_DATA_WIDTH-1:0]   data_out_r;
  logic                           valid_r;
  logic                           busy_r;
  logic                           ready_r;
  logic                           done_r;

  function automatic logic even_parity(input logic [AURORA_DATA_WIDTH-1:0] frame);
    return ^frame[AURORA_DATA_WIDTH-1:1];
  endfunction

  // Shifting the word right by idx*55 leaves the last frame's short tail zero-extended.
  function automatic logic [AURORA_DATA_WIDTH-1:0] build_frame(
    input logic [DATA_DFX_WIDTH-1:0] word,
    input logic [CNT_W-1:0]          idx
  );
    logic [AURORA_DATA_WIDTH-1:0] frame;
    frame = '0;
    frame[AURORA_DATA_WIDTH-1:HDR_W] = PAY_W'(word >> (32'(idx) * PAY_W));
    frame[8]   = (idx == {CNT_W{1'b0}});
    frame[7]   = (idx == LAST_CNT);
    frame[6:2] = idx;
    frame[1]   = 1'b0;
    frame[0]   = even_parity(frame);
    return frame;
  endfunction

  // Packet FSM: capture in IDLE, step through frames in SEND; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      word_r     <= '0;
      data_out_r <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (valid_dfx_in && ready_r) begin
            state_r    <= SEND;
            word_r     <= data_dfx_in;
            cnt_r      <= {CNT_W{1'b0}};
            data_out_r <= build_frame(data_dfx_in, {CNT_W{1'b0}});
            valid_r    <= 1'b1;
            busy_r     <= 1'b1;
            ready_r    <= 1'b0;
          end else begin
            data_out_r <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
          end
        end
        SEND: begin
          if (ready_out_dfx) begin
            if (cnt_r == LAST_CNT) begin
              state_r    <= IDLE;
              cnt_r      <= {CNT_W{1'b0}};
              data_out_r <= '0;
              valid_r    <= 1'b0;
              busy_r     <= 1'b0;
              ready_r    <= 1'b1;
              done_r     <= 1'b1;
            end else begin
              cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              data_out_r <= build_frame(word_r, cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
              done_r     <= 1'b0;
            end
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= {CNT_W{1'b0}};
          data_out_r <= '0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b0;
          ready_r    <= 1'b1;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_dfx_in   = ready_r;
  assign data_out_dfx   = data_out_r;
  assign valid_out_dfx  = valid_r;
  assign busy           = busy_r;
  assign done_encap_pkt = done_r;

endmodule

// File: tb/tb_encap_packet.sv
// Randomized bench for encap_packet: frames are compared against a bit-level model of the
// frame layout, and each packet is reassembled and compared with the word that was sent.
module tb_encap_packet;

  localparam int DFXW = 1034;
  localparam int LW   = 64;
  localparam int PW   = 55;
  localparam int NF   = 19;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DFXW-1:0] data_dfx_in = '0;
  logic            valid_dfx_in = 1'b0;
  logic            ready_dfx_in;
  logic [LW-1:0]   data_out_dfx;
  logic            valid_out_dfx;
  logic            ready_out_dfx = 1'b0;
  logic            busy;
  logic            done_encap_pkt;

  int errors = 0;
  int checks = 0;

  encap_packet dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_dfx_in    (data_dfx_in),
    .valid_dfx_in   (valid_dfx_in),
    .ready_dfx_in   (ready_dfx_in),
    .data_out_dfx   (data_out_dfx),
    .valid_out_dfx  (valid_out_dfx),
    .ready_out_dfx  (ready_out_dfx),
    .busy           (busy),
    .done_encap_pkt (done_encap_pkt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame k: payload bit j is word bit k*55+j (zero past the word end), then header and parity.
  function automatic logic [63:0] model_frame(input logic [DFXW-1:0] w, input int k);
    logic [63:0] f;
    logic [31:0] kv;
    int ones;
    f  = '0;
    kv = k;
    for (int j = 0; j < PW; j++) begin
      if (k * PW + j < DFXW) f[9 + j] = w[k * PW + j];
    end
    f[8]   = (k == 0) ? 1'b1 : 1'b0;
    f[7]   = (k == NF - 1) ? 1'b1 : 1'b0;
    f[6:2] = kv[4:0];
    ones = 0;
    for (int b = 1; b < 64; b++) ones += int'(f[b]);
    f[0] = (ones % 2 == 1) ? 1'b1 : 1'b0;
    return f;
  endfunction

  function automatic logic [DFXW-1:0] rand_word();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i * 32 +: 32] = $urandom;
    return t[DFXW-1:0];
  endfunction

  task automatic check_word(input string tag, input logic [DFXW-1:0] got, input logic [DFXW-1:0] exp);
    logic [1087:0] g;
    logic [1087:0] e;
    g = '0;
    e = '0;
    g[DFXW-1:0] = got;
    e[DFXW-1:0] = exp;
    for (int c = 0; c < 17; c++) check_eq(tag, g[c * 64 +: 64], e[c * 64 +: 64]);
  endtask

  // Called at #1 after an edge with the DUT idle; returns with the done cycle checked.
  task automatic send_packet(input logic [DFXW-1:0] w, input int stall_pct, input bit hold_next,
                             input logic [DFXW-1:0] next_w, output logic [DFXW-1:0] recon);
    logic [1087:0] rec;
    logic rdy;
    int k;
    int cyc;
    check_eq("ready_in_idle", 64'(ready_dfx_in), 64'd1);
    check_eq("valid_out_idle", 64'(valid_out_dfx), 64'd0);
    check_eq("busy_idle", 64'(busy), 64'd0);
    data_dfx_in  = w;
    valid_dfx_in = 1'b1;
    @(posedge clk); #1;
    if (hold_next) begin
      data_dfx_in = next_w;
    end else begin
      data_dfx_in  = rand_word();
      valid_dfx_in = ($urandom_range(0, 1) == 1);
    end
    rec = '0;
    k   = 0;
    cyc = 0;
    while (k < NF && cyc < 2000) begin
      rdy = ($urandom_range(0, 99) >= stall_pct);
      ready_out_dfx = rdy;
      check_eq("valid_out", 64'(valid_out_dfx), 64'd1);
      check_eq("busy", 64'(busy), 64'd1);
      check_eq("ready_in_send", 64'(ready_dfx_in), 64'd0);
      check_eq("done_low", 64'(done_encap_pkt), 64'd0);
      check_eq("frame", data_out_dfx, model_frame(w, k));
      if (rdy) begin
        for (int j = 0; j < PW; j++) rec[k * PW + j] = data_out_dfx[9 + j];
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) k++;
    end
    if (k < NF) check_eq("frame_timeout", 64'(k), 64'(NF));
    if (!hold_next) valid_dfx_in = 1'b0;
    check_eq("done_pulse", 64'(done_encap_pkt), 64'd1);
    check_eq("valid_out_after", 64'(valid_out_dfx), 64'd0);
    check_eq("data_out_after", data_out_dfx, 64'd0);
    check_eq("ready_in_after", 64'(ready_dfx_in), 64'd1);
    check_eq("busy_after", 64'(busy), 64'd0);
    recon = rec[DFXW-1:0];
  endtask

  initial begin
    logic [DFXW-1:0] w;
    logic [DFXW-1:0] w2;
    logic [DFXW-1:0] r;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out", data_out_dfx, 64'd0);
    check_eq("rst_valid_out", 64'(valid_out_dfx), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done_encap_pkt), 64'd0);
    check_eq("rst_ready_in", 64'(ready_dfx_in), 64'd1);
    rst_n = 1'b1;

    // Single set bit: frame 0 carries it at bit 9 with SOF.
    w = '0;
    w[0] = 1'b1;
    send_packet(w, 0, 1'b0, '0, r);
    check_word("recon_one", r, w);

    w = '1;
    send_packet(w, 0, 1'b0, '0, r);
    check_word("recon_ones", r, w);

    // valid held high across two words: second taken only after done.
    w  = rand_word();
    w2 = rand_word();
    send_packet(w, 0, 1'b1, w2, r);
    check_word("recon_hold_a", r, w);
    send_packet(w2, 0, 1'b0, '0, r);
    check_word("recon_hold_b", r, w2);

    for (int i = 0; i < 20; i++) begin
      w = rand_word();
      send_packet(w, 50, 1'b0, '0, r);
      check_word("recon_stall", r, w);
    end

    // Reset after the frame 7 transfer discards the packet.
    w = rand_word();
    data_dfx_in   = w;
    valid_dfx_in  = 1'b1;
    ready_out_dfx = 1'b1;
    @(posedge clk); #1;
    valid_dfx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_frame8", data_out_dfx, model_frame(w, 8));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_data", data_out_dfx, 64'd0);
    check_eq("mid_rst_valid", 64'(valid_out_dfx), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_done", 64'(done_encap_pkt), 64'd0);
    rst_n = 1'b1;
    w = rand_word();
    send_packet(w, 0, 1'b0, '0, r);
    check_word("recon_after_rst", r, w);

    for (int i = 0; i < 1000; i++) begin
      w = rand_word();
      send_packet(w, 25, 1'b0, '0, r);
      check_word("recon_rand", r, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
